// File: rtl/taxi_eth_tx_sched_pkg.sv
// Shared types and the round-robin pick function for the TX frame scheduler.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package taxi_eth_tx_sched_pkg;

    // The pick function works on a fixed maximum width so one definition
    // serves every source count from 2 to 16.
    localparam int RR_MAX   = 16;
    localparam int RR_IDX_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } sched_state_t;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // Search upward from (last + 1) mod n, wrapping, for the first set bit of
    // req. Bits at or above n are never examined.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0]   req,
                                         input logic [RR_IDX_W-1:0] last,
                                         input int unsigned         n);
        rr_pick_t            pick;
        logic [RR_IDX_W-1:0] cand;
        pick = '0;
        for (int unsigned k = 1; k <= RR_MAX; k++) begin
            cand = RR_IDX_W'((32'(last) + k) % n);
            if (k <= n && !pick.found && req[cand]) begin
                pick.found = 1'b1;
                pick.idx   = cand;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/taxi_rr_arb.sv
// Combinational round-robin picker: lowest-priority index is the last winner.
// Latency: zero (pure combinational).
// Backpressure: none; the caller decides when to register the winner.
// Ports: req (request vector), last (previous winner), grant (winner), found.
module taxi_rr_arb
    import taxi_eth_tx_sched_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] grant,
    output logic             found
);

    rr_pick_t pick;

    always_comb begin
        pick = rr_pick(RR_MAX'(req), RR_IDX_W'(last), N);
    end

    assign found = pick.found;
    assign grant = IDX_W'(pick.idx);

endmodule

// File: rtl/taxi_eth_tx_sched.sv
// Frame-level round-robin scheduler sharing one MAC TX AXI-Stream among N_SRC sources.
// Latency: one arbitration cycle per frame, then a zero-latency mux at one beat/cycle.
// Backpressure: m_tready is steered to the granted source's s_tready only; others see 0.
// Ports: s_* per-source AXI-Stream in (packed by source index), m_* to the MAC,
// m_tid = granted source, src_en arbitration mask, busy = frame in flight,
// grant_idx = current/last winner. Optional per-source frame counters (frame_cnt)
// are built when TAXI_ETH_TX_SCHED_STATS_EN is defined.
module taxi_eth_tx_sched
    import taxi_eth_tx_sched_pkg::*;
#(
    parameter int N_SRC  = 4,
    parameter int DATA_W = 8,
    parameter int ID_W   = 8,
    parameter int SRC_W  = $clog2(N_SRC)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_SRC*DATA_W-1:0] s_tdata,
    input  logic [N_SRC-1:0]        s_tvalid,
    output logic [N_SRC-1:0]        s_tready,
    input  logic [N_SRC-1:0]        s_tlast,
    input  logic [N_SRC-1:0]        s_tuser,
    output logic [DATA_W-1:0]       m_tdata,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    m_tlast,
    output logic                    m_tuser,
    output logic [ID_W-1:0]         m_tid,
    input  logic [N_SRC-1:0]        src_en,
    output logic                    busy,
    output logic [SRC_W-1:0]        grant_idx
`ifdef TAXI_ETH_TX_SCHED_STATS_EN
    ,
    output logic [N_SRC*32-1:0]     frame_cnt
`endif
);

    sched_state_t     state;
    sched_state_t     state_nxt;
    logic [SRC_W-1:0] last_idx;
    logic [SRC_W-1:0] arb_idx;
    logic             arb_found;
    logic [N_SRC-1:0] req;

    // src_en only matters here: once a frame is granted it runs to tlast.
    assign req = s_tvalid & src_en;

    taxi_rr_arb #(
        .N     (N_SRC),
        .IDX_W (SRC_W)
    ) u_arb (
        .req   (req),
        .last  (last_idx),
        .grant (arb_idx),
        .found (arb_found)
    );

    always_comb begin
        state_nxt = state;
        m_tdata   = '0;
        m_tvalid  = 1'b0;
        m_tlast   = 1'b0;
        m_tuser   = 1'b0;
        s_tready  = '0;
        if (state == XFER) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (grant_idx == SRC_W'(i)) begin
                    m_tdata     = s_tdata[i*DATA_W +: DATA_W];
                    m_tvalid    = s_tvalid[i];
                    m_tlast     = s_tlast[i];
                    m_tuser     = s_tuser[i];
                    s_tready[i] = m_tready;
                end
            end
            if (m_tvalid && m_tready && m_tlast) begin
                state_nxt = IDLE;
            end
        end else if (arb_found) begin
            state_nxt = XFER;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant_idx <= '0;
            // Start the rotation so that source 0 is first in line.
            last_idx  <= SRC_W'(N_SRC - 1);
        end else begin
            state <= state_nxt;
            if (state == IDLE && arb_found) begin
                grant_idx <= arb_idx;
                last_idx  <= arb_idx;
            end
        end
    end

    assign busy  = (state == XFER);
    assign m_tid = ID_W'(grant_idx);

`ifdef TAXI_ETH_TX_SCHED_STATS_EN
    logic [31:0] cnt [N_SRC];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SRC; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (s_tready[i] && s_tvalid[i] && s_tlast[i]) begin
                    cnt[i] <= cnt[i] + 32'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < N_SRC; g++) begin : g_cnt
        assign frame_cnt[g*32 +: 32] = cnt[g];
    end
`endif

endmodule

// File: tb/tb_taxi_eth_tx_sched.sv
// Self-checking bench for taxi_eth_tx_sched: directed scenarios then random traffic.
// Expected outputs come from a frame-level reference model and per-source frame generators.
// Stats checks are included when TAXI_ETH_TX_SCHED_STATS_EN is defined.
module tb_taxi_eth_tx_sched;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int IW = 8;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*DW-1:0] s_tdata;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tready;
    logic [N-1:0]    s_tlast;
    logic [N-1:0]    s_tuser;
    logic [DW-1:0]   m_tdata;
    logic            m_tvalid;
    logic            m_tready;
    logic            m_tlast;
    logic            m_tuser;
    logic [IW-1:0]   m_tid;
    logic [N-1:0]    src_en;
    logic            busy;
    logic [SW-1:0]   grant_idx;
`ifdef TAXI_ETH_TX_SCHED_STATS_EN
    logic [N*32-1:0] frame_cnt;
`endif

    taxi_eth_tx_sched #(
        .N_SRC  (N),
        .DATA_W (DW),
        .ID_W   (IW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .s_tlast   (s_tlast),
        .s_tuser   (s_tuser),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tlast   (m_tlast),
        .m_tuser   (m_tuser),
        .m_tid     (m_tid),
        .src_en    (src_en),
        .busy      (busy),
        .grant_idx (grant_idx)
`ifdef TAXI_ETH_TX_SCHED_STATS_EN
        ,
        .frame_cnt (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the output and who won last.
    bit mbusy;
    int mg;
    int mlast;
    int mfr [N];

    // Per-source frame generators.
    int         left  [N];  // beats remaining in the current frame (0 = nothing pending)
    int         bno   [N];  // beat number within the current frame
    int         fleft [N];  // queued follow-on frames of length flen
    int         flen  [N];
    logic [7:0] base  [N];
    bit         vg    [N];  // valid gate: 0 inserts a bubble
    bit         rnd_mode;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] beat_dat(input int i);
        return base[i] + 8'(bno[i] * 17);
    endfunction

    function automatic logic beat_user(input int i);
        return base[i][0] ^ bno[i][0];
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            s_tvalid[i]           = (left[i] > 0) && vg[i];
            s_tdata[i*DW +: DW]   = beat_dat(i);
            s_tlast[i]            = (left[i] == 1);
            s_tuser[i]            = beat_user(i);
        end
    endtask

    task automatic model_reset();
        mbusy = 1'b0;
        mg    = 0;
        mlast = N - 1;
        for (int i = 0; i < N; i++) mfr[i] = 0;
    endtask

    task automatic clear_agents();
        for (int i = 0; i < N; i++) begin
            left[i]  = 0;
            bno[i]   = 0;
            fleft[i] = 0;
            flen[i]  = 1;
            base[i]  = 8'h00;
            vg[i]    = 1'b1;
        end
        rnd_mode = 1'b0;
    endtask

    // One clock cycle: check outputs against the model, advance model and
    // generators, cross the edge, and present the next cycle's inputs.
    task automatic step();
        bit           exp_vld;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] r;
        drive();
        #1;
        exp_vld = mbusy && s_tvalid[mg];
        exp_rdy = '0;
        if (mbusy && m_tready) exp_rdy[mg] = 1'b1;
        chk("m_tvalid", 32'(m_tvalid), 32'(exp_vld));
        chk("s_tready", 32'(s_tready), 32'(exp_rdy));
        chk("busy", 32'(busy), 32'(mbusy));
        chk("grant_idx", 32'(grant_idx), 32'(mg));
        if (exp_vld) begin
            chk("m_tdata", 32'(m_tdata), 32'(beat_dat(mg)));
            chk("m_tlast", 32'(m_tlast), 32'(left[mg] == 1));
            chk("m_tuser", 32'(m_tuser), 32'(beat_user(mg)));
            chk("m_tid", 32'(m_tid), 32'(mg));
        end
        if (mbusy) begin
            if (exp_vld && m_tready && left[mg] == 1) begin
                mbusy = 1'b0;
                mfr[mg]++;
            end
        end else begin
            r = s_tvalid & src_en;
            for (int k = 1; k <= N; k++) begin
                if (r[(mlast + k) % N]) begin
                    mg    = (mlast + k) % N;
                    mlast = mg;
                    mbusy = 1'b1;
                    break;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (exp_rdy[i] && s_tvalid[i]) begin
                bno[i]++;
                left[i]--;
            end
            if (left[i] == 0) begin
                if (fleft[i] > 0) begin
                    fleft[i]--;
                    left[i] = flen[i];
                    bno[i]  = 0;
                    base[i] = base[i] + 8'h10;
                end else if (rnd_mode && $urandom_range(0, 3) == 0) begin
                    left[i] = $urandom_range(1, 5);
                    bno[i]  = 0;
                    base[i] = 8'($urandom);
                end
            end
        end
        @(posedge clk);
        #1;
        drive();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_agents();
        model_reset();
        src_en   = '1;
        m_tready = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive();
        #1;
    endtask

    initial begin
        int   got;
        int   c;
        logic [7:0] e;

        // Reset state.
        do_reset();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_s_tready", 32'(s_tready), 32'd0);
        chk("rst_grant_idx", 32'(grant_idx), 32'd0);

        // Source 2 alone: 3-beat frame 0x11, 0x22, 0x33.
        left[2] = 3;
        base[2] = 8'h11;
        step();
        chk("t1_dat0", 32'(m_tdata), 32'h11);
        chk("t1_tid", 32'(m_tid), 32'd2);
        chk("t1_last0", 32'(m_tlast), 32'd0);
        step();
        chk("t1_dat1", 32'(m_tdata), 32'h22);
        step();
        chk("t1_dat2", 32'(m_tdata), 32'h33);
        chk("t1_last2", 32'(m_tlast), 32'd1);
        step();
        chk("t1_busy_after", 32'(busy), 32'd0);

        // All sources streaming single-beat frames: tid 0,1,2,3,0 with a gap cycle.
        do_reset();
        for (int i = 0; i < N; i++) begin
            left[i]  = 1;
            flen[i]  = 1;
            fleft[i] = 3;
            base[i]  = 8'hA0 + 8'(i);
        end
        drive();
        #1;
        for (int k = 0; k < 10; k++) begin
            chk("t2_vld", 32'(m_tvalid), 32'(k % 2));
            if (k % 2 == 1) chk("t2_tid", 32'(m_tid), 32'((k / 2) % N));
            step();
        end
        clear_agents();

        // Source 1 with m_tready toggling 1,0,1,0: no beat lost or duplicated.
        left[1] = 4;
        base[1] = 8'h51;
        step();
        got = 0;
        c   = 0;
        while (got < 4 && c < 16) begin
            m_tready = (c % 2 == 0);
            #1;
            e = 8'h51 + 8'(got * 17);
            chk("t3_rdy", 32'(s_tready), 32'({2'b00, m_tready, 1'b0}));
            chk("t3_dat", 32'(m_tdata), 32'(e));
            if (m_tready) got++;
            step();
            c++;
        end
        chk("t3_beats", 32'(got), 32'd4);
        chk("t3_busy_after", 32'(busy), 32'd0);

        // src_en[1] dropped mid-frame: frame completes, 3 is next, 1 waits for re-enable.
        do_reset();
        left[1]  = 3;
        base[1]  = 8'h10;
        fleft[1] = 1;
        flen[1]  = 2;
        left[3]  = 1;
        base[3]  = 8'h30;
        step();
        chk("t4_grant1", 32'(grant_idx), 32'd1);
        chk("t4_busy1", 32'(busy), 32'd1);
        src_en[1] = 1'b0;
        repeat (3) step();
        chk("t4_gap", 32'(busy), 32'd0);
        step();
        chk("t4_grant3", 32'(grant_idx), 32'd3);
        chk("t4_tid3", 32'(m_tid), 32'd3);
        chk("t4_vld3", 32'(m_tvalid), 32'd1);
        step();
        for (int k = 0; k < 3; k++) begin
            chk("t4_held_off", 32'(busy), 32'd0);
            step();
        end
        src_en[1] = 1'b1;
        step();
        chk("t4_regrant_busy", 32'(busy), 32'd1);
        chk("t4_regrant_idx", 32'(grant_idx), 32'd1);
        repeat (3) step();

        // Reset asserted during beat 2 of a 5-beat frame from source 0.
        do_reset();
        left[0] = 5;
        base[0] = 8'h70;
        step();
        step();
        chk("t5_midframe_vld", 32'(m_tvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_vld", 32'(m_tvalid), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_rdy", 32'(s_tready), 32'd0);
        chk("t5_rst_grant", 32'(grant_idx), 32'd0);
        model_reset();
        clear_agents();
        left[0] = 2;
        base[0] = 8'h80;
        left[2] = 1;
        base[2] = 8'h90;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive();
        #1;
        step();
        chk("t5_first_win", 32'(grant_idx), 32'd0);
        chk("t5_first_busy", 32'(busy), 32'd1);
        repeat (6) step();

`ifdef TAXI_ETH_TX_SCHED_STATS_EN
        // Sources 0 and 3 send two frames each.
        do_reset();
        for (int i = 0; i < N; i += 3) begin
            left[i]  = 2;
            flen[i]  = 2;
            fleft[i] = 1;
            base[i]  = 8'(i * 16);
        end
        repeat (20) step();
        chk("st_cnt0", frame_cnt[0*32 +: 32], 32'd2);
        chk("st_cnt1", frame_cnt[1*32 +: 32], 32'd0);
        chk("st_cnt2", frame_cnt[2*32 +: 32], 32'd0);
        chk("st_cnt3", frame_cnt[3*32 +: 32], 32'd2);
`endif

        // Random traffic: bubbles, backpressure, enables, random frame lengths.
        do_reset();
        rnd_mode = 1'b1;
        for (int n = 0; n < 600; n++) begin
            m_tready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                src_en[i] = ($urandom_range(0, 4) != 0);
                vg[i]     = ($urandom_range(0, 4) != 0);
            end
            step();
        end
`ifdef TAXI_ETH_TX_SCHED_STATS_EN
        for (int i = 0; i < N; i++) begin
            chk("rnd_cnt", frame_cnt[i*32 +: 32], 32'(mfr[i]));
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/taxi_eth_tx_sched.md
# taxi_eth_tx_sched

Frame-level round-robin scheduler that shares the single transmit stream of the Ethernet MAC FIFO wrapper between `N_SRC` AXI4-Stream frame sources. A grant is held for the whole frame, from the first beat through `tlast`, so frames are never interleaved. Each frame is tagged on `tid` with its source index so that TX completions can be routed back. The block sits in the logic clock domain, between the requesters and the MAC `s_axis_tx`.

## Interface
- `N_SRC`, 4: number of sources, 2..16.
- `DATA_W`, 8: tdata width.
- `ID_W`, 8: output tid width; must be ≥ $clog2(N_SRC).
- `SRC_W`, $clog2(N_SRC): derived width of a source index.

Ports:
- `clk` in 1: the only clock.
- `rst_n` in 1: asynchronous assert, active-low reset.
- `s_tdata` in N_SRC*DATA_W: per-source data; source i occupies bits [i*DATA_W +: DATA_W].
- `s_tvalid` in N_SRC: per-source valid.
- `s_tready` out N_SRC: per-source ready.
- `s_tlast` in N_SRC: per-source end of frame.
- `s_tuser` in N_SRC: per-source bad-frame flag.
- `m_tdata` out DATA_W: data to the MAC.
- `m_tvalid` out 1: valid to the MAC.
- `m_tready` in 1: ready from the MAC.
- `m_tlast` out 1: end of frame to the MAC.
- `m_tuser` out 1: bad-frame flag to the MAC.
- `m_tid` out ID_W: source index, zero-extended.
- `src_en` in N_SRC: per-source arbitration enable.
- `busy` out 1: high while a frame is in flight.
- `grant_idx` out SRC_W: source currently or last granted.

## Operation
- States:
  - IDLE: no grant.
  - XFER: grant locked to `grant_idx`.
- Request vector: `req = s_tvalid & src_en`.
- IDLE → XFER when `req` is non-zero.
  - The winner is the first set bit of `req` found by searching upward from `(last + 1) mod N_SRC`, wrapping around.
  - `grant_idx` and `last` are both loaded with the winner.
- In XFER:
  - `m_*` is a combinational mux of the granted source.
  - `m_tid = grant_idx`.
  - `s_tready[grant_idx] = m_tready`; all other `s_tready` bits are 0.
- XFER → IDLE on a handshake beat (`m_tvalid && m_tready`) with `m_tlast = 1`.
- In IDLE, `m_tvalid = 0` and all `s_tready = 0`.
- `src_en` is sampled only at arbitration time.
  - Deasserting the granted source's enable mid-frame does not abort the frame; the frame completes.
- A granted source that drops `tvalid` mid-frame stalls the output, with `m_tvalid = 0`. The grant is held and there is no timeout.
- `busy` is high exactly when the state is XFER.
- A single-beat frame (`tlast` on the first beat) is legal.

## Timing
- Arbitration takes one cycle.
  - A request seen in IDLE at cycle t gives the first beat presented on `m_*` at cycle t+1.
- There is exactly one idle cycle between back-to-back frames, which is the IDLE arbitration cycle.
- Within a frame, latency is zero: a pure mux with no pipeline register. Full throughput is one beat per cycle.
- Reset values:
  - state IDLE, `busy = 0`, `m_tvalid = 0`, `s_tready = 0`.
  - `grant_idx = 0`.
  - `last = N_SRC-1`, so source 0 wins first.
- Reset asserted mid-frame:
  - All outputs go to their reset values asynchronously.
  - The partial frame is dropped with no `tlast`. Downstream FIFO bad-frame handling covers this case.
- Simultaneous requests resolve by round-robin from `last+1`.
  - A single persistent requester is re-granted every frame.

## Configuration
- `TAXI_ETH_TX_SCHED_STATS_EN` defined:
  - Adds output `frame_cnt` (N_SRC*32 bits).
  - Each per-source counter increments on that source's `tlast` handshake and wraps at 2^32.
  - Counters reset to 0.
- `TAXI_ETH_TX_SCHED_STATS_EN` undefined: the `frame_cnt` port and its counters are absent. All other behaviour is identical.

## Structure
- Shared package `taxi_eth_tx_sched_pkg`:
  - state enum `sched_state_t` {IDLE, XFER}.
  - function `rr_pick(req, last)`, which returns the winner index and a found flag.
- Natural sub-module: `taxi_rr_arb`, a combinational round-robin priority picker parameterized by N, reusable elsewhere.
- The top level holds the FSM, grant registers, datapath mux and optional counters.

## Test plan
- Reset, then only source 2 sends a 3-beat frame (0x11, 0x22, 0x33) with `m_tready = 1` → `m_tdata` 0x11/0x22/0x33 on cycles t+1..t+3, `m_tid = 2`, `m_tlast` on 0x33, `busy` falls after the last beat.
- All 4 sources continuously request 1-beat frames → `m_tid` sequence 0,1,2,3,0…, with one idle cycle between frames.
- Source 1 mid-frame with `m_tready` toggled 1,0,1,0 → no beat lost or duplicated; `s_tready[1]` mirrors `m_tready`; other readies stay 0.
- `src_en[1]` cleared during source 1's frame, sources 1 and 3 requesting → source 1's frame completes; the next grant goes to 3; source 1 is not granted again until re-enabled.
- `rst_n` pulsed low during beat 2 of a 5-beat frame → `m_tvalid` 0 immediately; after release the source 0 request wins first.
- STATS_EN build, sources 0 and 3 send 2 frames each → `frame_cnt[0] = 2`, `frame_cnt[3] = 2`, others 0.
